// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares one single-port synchronous data RAM between the two pipeline
// memory ports. p0 (older) wins a same-cycle conflict. p1 is parked in a
// holding register and replayed the following cycle while `stall` freezes
// both pipelines for the conflict cycle. Two stores from the same pair to
// the same address collapse into the younger (p1) store. A saturating
// counter records every serialized conflict.

module dm_port_arbiter #(
    parameter int AW    = 9,
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             p0_req,
    input  logic             p0_write_mem,
    input  logic [AW-1:0]    p0_maddr,
    input  logic [DW-1:0]    p0_wdata,
    output logic [DW-1:0]    p0_rdata,
    output logic             p0_rvalid,

    input  logic             p1_req,
    input  logic             p1_write_mem,
    input  logic [AW-1:0]    p1_maddr,
    input  logic [DW-1:0]    p1_wdata,
    output logic [DW-1:0]    p1_rdata,
    output logic             p1_rvalid,

    output logic [AW-1:0]    mem_maddr,
    output logic [DW-1:0]    mem_wdata,
    output logic             mem_write,
    input  logic [DW-1:0]    mem_rdata,

    output logic             stall,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    // Which port a read issued this cycle belongs to; used one cycle later
    // to steer mem_rdata into the right return register.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Arbiter state and the parked p1 request.
    state_t          state_q,      state_d;
    logic [AW-1:0]   hold_addr_q,  hold_addr_d;
    logic [DW-1:0]   hold_wdata_q, hold_wdata_d;
    logic            hold_write_q, hold_write_d;

    // Last address/data presented to the RAM, held while nobody requests.
    logic [AW-1:0]   last_addr_q;
    logic [DW-1:0]   last_wdata_q;

    logic [CNT_W-1:0] cnt_q;
    owner_t           rd_owner_q;

    logic [DW-1:0]   p0_rdata_q, p1_rdata_q;
    logic            p0_rvalid_q, p1_rvalid_q;

    // Current-cycle selection.
    logic            sel_valid_s;
    logic            sel_write_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;
    owner_t          sel_owner_s;
    logic            conflict_s;

    logic            both_req_s;
    logic            dual_store_s;

    assign both_req_s   = p0_req & p1_req;
    // Both stores to one address: the younger store is the architecturally
    // visible one, so the older store can simply be dropped.
    assign dual_store_s = both_req_s & p0_write_mem & p1_write_mem
                          & (p0_maddr == p1_maddr);

    // Select which request owns the RAM this cycle and compute next state.
    always_comb begin
        sel_valid_s  = 1'b0;
        sel_write_s  = 1'b0;
        sel_addr_s   = last_addr_q;
        sel_wdata_s  = last_wdata_q;
        sel_owner_s  = OWN_NONE;
        conflict_s   = 1'b0;
        state_d      = state_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_write_d = hold_write_q;

        case (state_q)
            ST_IDLE: begin
                if (both_req_s && !dual_store_s) begin
                    // Real conflict: older port first, park the younger one.
                    sel_valid_s  = 1'b1;
                    sel_write_s  = p0_write_mem;
                    sel_addr_s   = p0_maddr;
                    sel_wdata_s  = p0_wdata;
                    sel_owner_s  = OWN_P0;
                    conflict_s   = 1'b1;
                    hold_addr_d  = p1_maddr;
                    hold_wdata_d = p1_wdata;
                    hold_write_d = p1_write_mem;
                    state_d      = ST_REPLAY;
                end else if (p1_req) begin
                    // p1 alone, or the collapsed same-address store pair.
                    sel_valid_s  = 1'b1;
                    sel_write_s  = p1_write_mem;
                    sel_addr_s   = p1_maddr;
                    sel_wdata_s  = p1_wdata;
                    sel_owner_s  = OWN_P1;
                end else if (p0_req) begin
                    sel_valid_s  = 1'b1;
                    sel_write_s  = p0_write_mem;
                    sel_addr_s   = p0_maddr;
                    sel_wdata_s  = p0_wdata;
                    sel_owner_s  = OWN_P0;
                end else begin
                    sel_valid_s  = 1'b0;
                end
            end
            ST_REPLAY: begin
                // Port requests are ignored while the parked p1 access runs.
                sel_valid_s = 1'b1;
                sel_write_s = hold_write_q;
                sel_addr_s  = hold_addr_q;
                sel_wdata_s = hold_wdata_q;
                sel_owner_s = OWN_P1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM drive and stall are combinational; reset forces them quiet at once
    // so a parked store cannot reach the RAM while reset is asserted.
    always_comb begin
        if (rst) begin
            mem_write = 1'b0;
            mem_maddr = '0;
            mem_wdata = '0;
            stall     = 1'b0;
        end else begin
            mem_write = sel_valid_s & sel_write_s;
            mem_maddr = sel_addr_s;
            mem_wdata = sel_wdata_s;
            stall     = conflict_s;
        end
    end

    // Arbiter FSM together with the p1 holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_write_q <= hold_write_d;
        end
    end

    // Remember the last RAM address/data so idle cycles keep them steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else if (sel_valid_s) begin
            last_addr_q  <= sel_addr_s;
            last_wdata_q <= sel_wdata_s;
        end else begin
            last_addr_q  <= last_addr_q;
            last_wdata_q <= last_wdata_q;
        end
    end

    // Saturating count of serialized conflicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (conflict_s && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Tag each issued read with its owner for the next-cycle return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_q <= OWN_NONE;
        end else if (sel_valid_s && !sel_write_s) begin
            rd_owner_q <= sel_owner_s;
        end else begin
            rd_owner_q <= OWN_NONE;
        end
    end

    // Capture returning RAM data into the owning port's register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            p0_rvalid_q <= (rd_owner_q == OWN_P0);
            p1_rvalid_q <= (rd_owner_q == OWN_P1);
            case (rd_owner_q)
                OWN_P0:  p0_rdata_q <= mem_rdata;
                OWN_P1:  p1_rdata_q <= mem_rdata;
                default: begin
                    p0_rdata_q <= p0_rdata_q;
                    p1_rdata_q <= p1_rdata_q;
                end
            endcase
        end
    end

    assign p0_rdata     = p0_rdata_q;
    assign p1_rdata     = p1_rdata_q;
    assign p0_rvalid    = p0_rvalid_q;
    assign p1_rvalid    = p1_rvalid_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed stimulus, a transaction-level model
// (reference memory plus a queue of pending read returns) checked every
// cycle, and literal expectations at the key points of each scenario.
// A second instance with a 2-bit counter shares the stimulus to exercise
// counter saturation.

module tb_dm_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          p0_req = 1'b0, p0_write_mem = 1'b0;
    logic [AW-1:0] p0_maddr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_write_mem = 1'b0;
    logic [AW-1:0] p1_maddr = '0;
    logic [DW-1:0] p1_wdata = '0;

    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          p0_rvalid, p1_rvalid;
    logic [AW-1:0] mem_maddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          stall;
    logic [15:0]   conflict_cnt;

    logic [DW-1:0] s_p0_rdata, s_p1_rdata;
    logic          s_p0_rvalid, s_p1_rvalid;
    logic [AW-1:0] s_mem_maddr;
    logic [DW-1:0] s_mem_wdata;
    logic          s_mem_write;
    logic          s_stall;
    logic [1:0]    s_conflict_cnt;

    always #5 clk = ~clk;

    dm_port_arbiter #(.AW(AW), .DW(DW), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_write_mem(p0_write_mem), .p0_maddr(p0_maddr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_write_mem(p1_write_mem), .p1_maddr(p1_maddr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .mem_maddr(mem_maddr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .stall(stall), .conflict_cnt(conflict_cnt)
    );

    dm_port_arbiter #(.AW(AW), .DW(DW), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_write_mem(p0_write_mem), .p0_maddr(p0_maddr),
        .p0_wdata(p0_wdata), .p0_rdata(s_p0_rdata), .p0_rvalid(s_p0_rvalid),
        .p1_req(p1_req), .p1_write_mem(p1_write_mem), .p1_maddr(p1_maddr),
        .p1_wdata(p1_wdata), .p1_rdata(s_p1_rdata), .p1_rvalid(s_p1_rvalid),
        .mem_maddr(s_mem_maddr), .mem_wdata(s_mem_wdata), .mem_write(s_mem_write),
        .mem_rdata(mem_rdata), .stall(s_stall), .conflict_cnt(s_conflict_cnt)
    );

    // Single-port synchronous RAM driven by the main instance.
    logic [DW-1:0] ram [0:511];
    always @(posedge clk) begin
        if (mem_write) ram[mem_maddr] <= mem_wdata;
        mem_rdata <= ram[mem_maddr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int            owner;   // 0 = p0, 1 = p1
        logic [DW-1:0] data;
        int            due;     // model cycle at which rdata/rvalid show it
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] ref_mem [0:511];
    bit            m_pend;
    logic [AW-1:0] m_h_addr;
    logic [DW-1:0] m_h_wdata;
    bit            m_h_we;
    int            m_cnt;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_p0_rdata, m_p1_rdata;
    int            cyc = 0;

    initial begin : compare_proc
        bit            srv, s_we, s_stl, s_newpend, was_rst, e0v, e1v;
        int            s_own;
        logic [AW-1:0] s_addr, t_addr;
        logic [DW-1:0] s_wd, t_wd;
        bit            t_we;
        m_pend = 1'b0; m_cnt = 0; m_last_addr = '0;
        m_p0_rdata = '0; m_p1_rdata = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            was_rst = rst;
            srv = 1'b0; s_we = 1'b0; s_stl = 1'b0; s_newpend = 1'b0; s_own = 0;
            s_addr = '0; s_wd = '0; t_addr = '0; t_wd = '0; t_we = 1'b0;
            if (rst) begin
                m_pend = 1'b0; m_cnt = 0; m_last_addr = '0;
                m_p0_rdata = '0; m_p1_rdata = '0;
                rq.delete();
                check("rst_mem_write", {31'd0, mem_write}, 32'd0);
                check("rst_stall",     {31'd0, stall}, 32'd0);
                check("rst_mem_maddr", {23'd0, mem_maddr}, 32'd0);
                check("rst_p0_rdata",  {16'd0, p0_rdata}, 32'd0);
                check("rst_p1_rdata",  {16'd0, p1_rdata}, 32'd0);
                check("rst_rvalid",    {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
                check("rst_cnt",       {16'd0, conflict_cnt}, 32'd0);
            end else begin
                // Who owns the RAM this cycle, from the arbitration rules.
                if (m_pend) begin
                    srv = 1; s_addr = m_h_addr; s_wd = m_h_wdata; s_we = m_h_we; s_own = 1;
                end else if (p0_req && p1_req) begin
                    if (p0_write_mem && p1_write_mem && p0_maddr == p1_maddr) begin
                        srv = 1; s_addr = p1_maddr; s_wd = p1_wdata; s_we = 1; s_own = 1;
                    end else begin
                        srv = 1; s_addr = p0_maddr; s_wd = p0_wdata; s_we = p0_write_mem; s_own = 0;
                        s_stl = 1; s_newpend = 1;
                        t_addr = p1_maddr; t_wd = p1_wdata; t_we = p1_write_mem;
                    end
                end else if (p0_req) begin
                    srv = 1; s_addr = p0_maddr; s_wd = p0_wdata; s_we = p0_write_mem; s_own = 0;
                end else if (p1_req) begin
                    srv = 1; s_addr = p1_maddr; s_wd = p1_wdata; s_we = p1_write_mem; s_own = 1;
                end

                e0v = 1'b0; e1v = 1'b0;
                while (rq.size() > 0 && rq[0].due == cyc) begin
                    if (rq[0].owner == 0) begin e0v = 1; m_p0_rdata = rq[0].data; end
                    else begin e1v = 1; m_p1_rdata = rq[0].data; end
                    void'(rq.pop_front());
                end

                check("stall",     {31'd0, stall}, {31'd0, s_stl});
                check("mem_write", {31'd0, mem_write}, {31'd0, srv && s_we});
                check("mem_maddr", {23'd0, mem_maddr}, {23'd0, srv ? s_addr : m_last_addr});
                if (srv && s_we) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, s_wd});
                check("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, e0v});
                check("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, e1v});
                check("p0_rdata",  {16'd0, p0_rdata}, {16'd0, m_p0_rdata});
                check("p1_rdata",  {16'd0, p1_rdata}, {16'd0, m_p1_rdata});
                check("cnt16", {16'd0, conflict_cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
                check("cnt2",  {30'd0, s_conflict_cnt}, (m_cnt > 3) ? 32'd3 : m_cnt);

                if (srv && !s_we) rq.push_back('{owner: s_own, data: ref_mem[s_addr], due: cyc + 2});
            end
            @(posedge clk);
            if (!was_rst && !rst) begin
                if (srv && s_we) ref_mem[s_addr] = s_wd;
                if (srv) m_last_addr = s_addr;
                if (s_newpend) begin
                    m_pend = 1'b1; m_h_addr = t_addr; m_h_wdata = t_wd; m_h_we = t_we;
                end else begin
                    m_pend = 1'b0;
                end
                if (s_stl) m_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs just after the clock edge, return at the
    // following falling edge so literal checks can sample stable outputs.
    task automatic drive(input logic a0r, input logic a0w, input logic [AW-1:0] a0a,
                         input logic [DW-1:0] a0d, input logic a1r, input logic a1w,
                         input logic [AW-1:0] a1a, input logic [DW-1:0] a1d);
        @(posedge clk); #1;
        p0_req = a0r; p0_write_mem = a0w; p0_maddr = a0a; p0_wdata = a0d;
        p1_req = a1r; p1_write_mem = a1w; p1_maddr = a1a; p1_wdata = a1d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
    endtask

    task automatic set_idle_inputs();
        p0_req = 1'b0; p0_write_mem = 1'b0; p0_maddr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_write_mem = 1'b0; p1_maddr = '0; p1_wdata = '0;
    endtask

    initial begin : main_proc
        for (int i = 0; i < 512; i++) ram[i] = '0;

        // Reset, then idle.
        @(negedge clk);
        check("lit_rst_cnt",   {16'd0, conflict_cnt}, 32'd0);
        check("lit_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            check("lit_idle_stall", {31'd0, stall}, 32'd0);
        end

        // Single port store then load.
        drive(1'b1, 1'b1, 9'h010, 16'h1234, 1'b0, 1'b0, 9'h000, 16'h0000);
        check("lit_sp_write", {31'd0, mem_write}, 32'd1);
        drive(1'b1, 1'b0, 9'h010, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
        check("lit_sp_read", {31'd0, mem_write}, 32'd0);
        idle(); idle();
        check("lit_sp_rdata",  {16'd0, p0_rdata}, 32'h1234);
        check("lit_sp_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd2);

        // Conflict: p0 store, p1 load of the same word.
        drive(1'b1, 1'b1, 9'h020, 16'hBEEF, 1'b1, 1'b0, 9'h020, 16'h0000);
        check("lit_raw_stall", {31'd0, stall}, 32'd1);
        check("lit_raw_wr",    {31'd0, mem_write}, 32'd1);
        check("lit_raw_addr",  {23'd0, mem_maddr}, 32'h020);
        drive(1'b1, 1'b1, 9'h020, 16'hBEEF, 1'b1, 1'b0, 9'h020, 16'h0000);
        check("lit_replay_stall", {31'd0, stall}, 32'd0);
        check("lit_replay_rd",    {31'd0, mem_write}, 32'd0);
        check("lit_replay_addr",  {23'd0, mem_maddr}, 32'h020);
        idle(); idle();
        check("lit_raw_rdata",  {16'd0, p1_rdata}, 32'hBEEF);
        check("lit_raw_rvalid", {31'd0, p1_rvalid}, 32'd1);
        check("lit_raw_cnt",    {16'd0, conflict_cnt}, 32'd1);

        // Dual store to one address: younger store wins, no stall.
        drive(1'b1, 1'b1, 9'h030, 16'h1111, 1'b1, 1'b1, 9'h030, 16'h2222);
        check("lit_ds_stall", {31'd0, stall}, 32'd0);
        check("lit_ds_wdata", {16'd0, mem_wdata}, 32'h2222);
        idle();
        drive(1'b1, 1'b0, 9'h030, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
        idle(); idle();
        check("lit_ds_rdata", {16'd0, p0_rdata}, 32'h2222);
        check("lit_ds_cnt",   {16'd0, conflict_cnt}, 32'd1);

        // p0 load then p1 store to the same address: p0 sees the old value.
        drive(1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b1, 9'h050, 16'h0ABC);
        drive(1'b1, 1'b0, 9'h050, 16'h0000, 1'b1, 1'b1, 9'h050, 16'h7777);
        drive(1'b1, 1'b0, 9'h050, 16'h0000, 1'b1, 1'b1, 9'h050, 16'h7777);
        idle();
        check("lit_war_rdata", {16'd0, p0_rdata}, 32'h0ABC);
        drive(1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h050, 16'h0000);
        idle(); idle();
        check("lit_war_new", {16'd0, p1_rdata}, 32'h7777);

        // Reset, then four back-to-back conflicting pairs.
        @(posedge clk); #1; set_idle_inputs(); rst = 1'b1;
        @(negedge clk);
        check("lit_rst2_cnt", {16'd0, conflict_cnt}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 9'h060 + 9'(i / 2), 16'h0000, 1'b1, 1'b0, 9'h070 + 9'(i / 2), 16'h0000);
            check("lit_b2b_stall", {31'd0, stall}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        idle();
        check("lit_b2b_cnt", {16'd0, conflict_cnt}, 32'd4);
        check("lit_sat_cnt", {30'd0, s_conflict_cnt}, 32'd3);
        idle(); idle();

        // Reset while the parked p1 store waits for its replay.
        drive(1'b1, 1'b0, 9'h041, 16'h0000, 1'b1, 1'b1, 9'h040, 16'h5555);
        check("lit_rr_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1; set_idle_inputs();
        #1 rst = 1'b1;
        #1;
        check("lit_rr_stall0", {31'd0, stall}, 32'd0);
        check("lit_rr_nowr",   {31'd0, mem_write}, 32'd0);
        check("lit_rr_addr",   {23'd0, mem_maddr}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        drive(1'b1, 1'b0, 9'h040, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
        idle(); idle();
        check("lit_rr_rdata",  {16'd0, p0_rdata}, 32'h0000);
        check("lit_rr_rvalid", {31'd0, p0_rvalid}, 32'd1);
        // A fresh single p1 load proceeds normally: the arbiter is idle again.
        drive(1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h020, 16'h0000);
        check("lit_rr_idle_stall", {31'd0, stall}, 32'd0);
        idle(); idle();
        check("lit_rr_p1", {16'd0, p1_rdata}, 32'hBEEF);

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares one single-port synchronous data RAM between the two pipeline memory ports, p0 and p1.
- p0 is the older instruction of an issue pair; p1 is the younger.
- On a same-cycle conflict, p0 is served first. The p1 request is held and replayed the next cycle, and `stall` freezes both pipelines (fed to HCU alongside `fetch_next` gating).
- Keeps a saturating conflict counter for performance analysis.

Parameters:
- AW, 9, memory address width
- DW, 16, data width
- CNT_W, 16, conflict counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- p0_req  in  1  p0 stage-3 memory access valid
- p0_write_mem  in  1  p0 access is a store
- p0_maddr  in  AW  p0 address
- p0_wdata  in  DW  p0 store data
- p0_rdata  out  DW  p0 load data, registered
- p0_rvalid  out  1  p0_rdata updated this cycle
- p1_req  in  1  p1 access valid
- p1_write_mem  in  1  p1 store
- p1_maddr  in  AW  p1 address
- p1_wdata  in  DW  p1 store data
- p1_rdata  out  DW  p1 load data, registered
- p1_rvalid  out  1  p1_rdata updated this cycle
- mem_maddr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_write  out  1  RAM write enable
- mem_rdata  in  DW  RAM read data, valid 1 cycle after address
- stall  out  1  freeze both pipelines this cycle
- conflict_cnt  out  CNT_W  saturating count of serialized conflicts

Behaviour:
- Reset (async, rst=1):
  - State=IDLE.
  - Holding register cleared.
  - p0_rdata=p1_rdata=0, p0_rvalid=p1_rvalid=0.
  - stall=0, mem_write=0, mem_maddr=0, mem_wdata=0, conflict_cnt=0.
  - Reset mid-replay discards the held p1 request; no RAM write issues.
- RAM driving: mem_* outputs are combinational from the current selection. Read latency is 1 cycle.
- Read return: an owner tag (none/p0/p1) is registered with each read. Next cycle, mem_rdata is captured into that owner's rdata register and its rvalid pulses for 1 cycle. The other rdata register holds its value.
- State IDLE:
  - No req: mem_write=0, mem_maddr holds its last value, stall=0.
  - Exactly one req: that request drives RAM; stall=0.
  - Both req, both stores, same address: only p1's store issues (the younger store wins). p0's store is dropped; stall=0; counter unchanged.
  - Both req, any other case: p0 drives RAM. p1's addr, wdata and write flag latch into the holding register. stall=1, conflict_cnt += 1 (saturates at all-ones), next state REPLAY.
- State REPLAY:
  - Held p1 request drives RAM; stall=0; p0_req and p1_req are ignored this cycle.
  - p0 read data (if any) returns this cycle; p1 read data returns the next cycle.
  - Next state IDLE.
- Ordering guarantees:
  - p0 store then p1 load to the same address: p1 reads the new value.
  - p0 load then p1 store to the same address: p0 reads the old value.
- Max throughput: 2 accesses per 2 cycles under a continuous conflict, 1 per cycle otherwise.
- stall is never asserted two consecutive cycles.

Test Plan:
- Reset then idle, rst released with no reqs → all outputs 0, stall=0 for 5 cycles.
- Single port:
  - p0 store 0x1234 @0x010, next cycle p0 load @0x010 → mem_write=1 then 0. One cycle later p0_rdata=0x1234, p0_rvalid=1, p1_rvalid=0.
- Conflict RAW:
  - Same cycle: p0 store 0xBEEF @0x020, p1 load @0x020.
  - Expected: stall=1 one cycle, mem_write=1 @0x020, then REPLAY read @0x020.
  - Then p1_rdata=0xBEEF with p1_rvalid=1; conflict_cnt=1.
- Dual store, same address:
  - Same cycle: p0 store 0x1111 @0x030, p1 store 0x2222 @0x030.
  - Expected: stall=0, a single write of 0x2222; a later load returns 0x2222; conflict_cnt unchanged.
- Back-to-back conflicts: 4 consecutive conflicting cycle-pairs → stall pattern 1,0,1,0,…; conflict_cnt=4. Saturation: preload CNT_W=2 → the count stops at 3.
- Reset in REPLAY:
  - Conflict with p1 store 0x5555 @0x040; assert rst during REPLAY.
  - Expected: no write to 0x040 occurs, state=IDLE, stall=0 immediately on rst.
